wb_sdrc_arb: RTL and testbench

WB_SDRC_ARB -- requirements
Module: wb_sdrc_arb

---
 rtl/wb_sdrc_arb_if.sv | 52 +++++
 rtl/wb_sdrc_arb.sv | 131 +++++++++++++
 tb/tb_wb_sdrc_arb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sdrc_arb_if.sv
// Bundled Wishbone signals between two masters, the arbiter and the SDRAM bridge.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface wb_sdrc_arb_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic            m0_cyc_i, m0_stb_i, m0_we_i;
  logic [aw-1:0]   m0_addr_i;
  logic [dw-1:0]   m0_dat_i;
  logic [dw/8-1:0] m0_sel_i;
  logic [2:0]      m0_cti_i;
  logic            m0_ack_o, m0_err_o;
  logic [dw-1:0]   m0_dat_o;

  logic            m1_cyc_i, m1_stb_i, m1_we_i;
  logic [aw-1:0]   m1_addr_i;
  logic [dw-1:0]   m1_dat_i;
  logic [dw/8-1:0] m1_sel_i;
  logic [2:0]      m1_cti_i;
  logic            m1_ack_o, m1_err_o;
  logic [dw-1:0]   m1_dat_o;

  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [aw-1:0]   s_addr_o;
  logic [dw-1:0]   s_dat_o;
  logic [dw/8-1:0] s_sel_o;
  logic [2:0]      s_cti_o;
  logic            s_ack_i;
  logic [dw-1:0]   s_dat_i;

  logic [1:0]      grant_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i, m0_cti_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i, m1_cti_i,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    input  s_ack_i, s_dat_i,
    output grant_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i, m0_cti_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i, m1_cti_i,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    output s_ack_i, s_dat_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_sdrc_arb.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM bridge, with a
// per-ownership stall timeout that aborts the cycle and pulses err to the owner.
//
// state | meaning
// IDLE  | no owner, slave bus driven to zero, acks dropped
// OWN0  | master 0 owns the bridge
// OWN1  | master 1 owns the bridge
module wb_sdrc_arb #(
  parameter int dw     = 32,
  parameter int aw     = 32,
  parameter int TO_CYC = 255
) (
  input logic          wb_clk_i,
  input logic          wb_rst_i,
  wb_sdrc_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  state_t          state, state_nxt;
  logic            last, last_nxt;
  logic [7:0]      stall_cnt, stall_nxt;

  logic            sel_cyc, sel_stb, sel_we, sel_ack;
  logic [2:0]      sel_cti;
  logic [aw-1:0]   sel_addr;
  logic [dw-1:0]   sel_dat;
  logic [dw/8-1:0] sel_sel;
  logic            timeout;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      last      <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  // Owner mux; IDLE leaves everything at zero so stray acks go nowhere.
  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_ack  = 1'b0;
    sel_cti  = '0;
    sel_addr = '0;
    sel_dat  = '0;
    sel_sel  = '0;
    case (state)
      OWN0: begin
        sel_cyc  = bus.m0_cyc_i;
        sel_stb  = bus.m0_stb_i;
        sel_we   = bus.m0_we_i;
        sel_cti  = bus.m0_cti_i;
        sel_addr = bus.m0_addr_i;
        sel_dat  = bus.m0_dat_i;
        sel_sel  = bus.m0_sel_i;
        sel_ack  = bus.s_ack_i;
      end
      OWN1: begin
        sel_cyc  = bus.m1_cyc_i;
        sel_stb  = bus.m1_stb_i;
        sel_we   = bus.m1_we_i;
        sel_cti  = bus.m1_cti_i;
        sel_addr = bus.m1_addr_i;
        sel_dat  = bus.m1_dat_i;
        sel_sel  = bus.m1_sel_i;
        sel_ack  = bus.s_ack_i;
      end
      default: ;
    endcase
  end

  assign timeout = (state != IDLE) && (stall_cnt == TO_LIM);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    stall_nxt = stall_cnt;
    case (state)
      IDLE: begin
        stall_nxt = '0;
        // last=1 means master 1 was served most recently, so master 0 wins a tie
        if (bus.m0_cyc_i && (!bus.m1_cyc_i || last)) begin
          state_nxt = OWN0;
          last_nxt  = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_nxt = OWN1;
          last_nxt  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (timeout || sel_ack)
          stall_nxt = '0;
        else if (sel_stb)
          stall_nxt = stall_cnt + 8'd1;
        if (timeout || !sel_cyc || (sel_ack && sel_cti == 3'b111))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.s_cyc_o  = sel_cyc & ~timeout;
  assign bus.s_stb_o  = sel_stb & ~timeout;
  assign bus.s_we_o   = sel_we;
  assign bus.s_cti_o  = sel_cti;
  assign bus.s_addr_o = sel_addr;
  assign bus.s_dat_o  = sel_dat;
  assign bus.s_sel_o  = sel_sel;

  assign bus.m0_ack_o = (state == OWN0) & bus.s_ack_i;
  assign bus.m1_ack_o = (state == OWN1) & bus.s_ack_i;
  assign bus.m0_err_o = (state == OWN0) & timeout;
  assign bus.m1_err_o = (state == OWN1) & timeout;
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

  assign bus.grant_o  = state;

endmodule

// File: tb/tb_wb_sdrc_arb.sv
// Self-checking bench for wb_sdrc_arb: scoreboarded beats, arbitration order,
// stall timeout, idle ack drop and asynchronous reset abort.
module tb_wb_sdrc_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_sdrc_arb_if #(.dw(32), .aw(32)) bus ();

  wb_sdrc_arb #(.dw(32), .aw(32), .TO_CYC(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive_m(input int m, input logic stb, input logic we, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
    if (m == 0) begin
      bus.m0_stb_i = stb; bus.m0_we_i = we; bus.m0_addr_i = addr;
      bus.m0_dat_i = dat; bus.m0_sel_i = sel; bus.m0_cti_i = cti;
    end else begin
      bus.m1_stb_i = stb; bus.m1_we_i = we; bus.m1_addr_i = addr;
      bus.m1_dat_i = dat; bus.m1_sel_i = sel; bus.m1_cti_i = cti;
    end
  endtask

  task automatic sample_ack();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("ack_vec",  32'({bus.m1_ack_o, bus.m0_ack_o}), 32'(oh(e.m)));
      chk("grant",    32'(bus.grant_o), 32'(oh(e.m)));
      chk("s_addr",   bus.s_addr_o, e.addr);
      chk("s_we",     32'(bus.s_we_o), 32'(e.we));
      chk("s_dat",    bus.s_dat_o, e.wdat);
      chk("s_sel",    32'(bus.s_sel_o), 32'(e.sel));
      chk("m_dat",    (e.m == 0) ? bus.m0_dat_o : bus.m1_dat_o, e.rdat);
    end
  endtask

  // Called and returns at the drive phase (just after a rising edge).
  task automatic beat(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                      input logic [3:0] sel, input logic [2:0] cti, input logic [31:0] rdat,
                      input int waits);
    exp_t e;
    drive_m(m, 1'b1, we, addr, wdat, sel, cti);
    bus.s_ack_i = 1'b0;
    for (int i = 0; i < waits; i++) begin
      look();
      chk("wait_addr", bus.s_addr_o, addr);
      chk("wait_stb",  32'(bus.s_stb_o), 32'd1);
      chk("wait_ack",  32'({bus.m1_ack_o, bus.m0_ack_o}), 32'd0);
      tick();
    end
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = rdat;
    e.m = m; e.we = we; e.addr = addr; e.wdat = wdat; e.sel = sel; e.rdat = rdat;
    sb.push_back(e);
    look();
    sample_ack();
    tick();
    bus.s_ack_i = 1'b0;
    drive_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
  endtask

  initial begin
    int n;
    bus.m0_cyc_i = 0; bus.m1_cyc_i = 0;
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    bus.s_ack_i = 0; bus.s_dat_i = 32'h0;

    look();
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst_acks",  32'({bus.m1_ack_o, bus.m0_ack_o, bus.m1_err_o, bus.m0_err_o}), 32'd0);
    tick();
    rst = 1'b0;

    // Simultaneous requests: m0 first, then m1 after one idle cycle
    tick();
    bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
    look();
    chk("grant_latency", 32'(bus.grant_o), 32'd0);
    tick();
    look();
    chk("first_arb_m0", 32'(bus.grant_o), 32'h1);
    chk("s_cyc_mirror", 32'(bus.s_cyc_o), 32'd1);
    tick();
    beat(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b111, 32'h12345678, 0);
    look();
    chk("idle_gap", 32'(bus.grant_o), 32'd0);
    tick();
    look();
    chk("rr_m1", 32'(bus.grant_o), 32'h2);

    // m1 write, one wait state; m0 still requesting
    tick();
    beat(1, 1'b1, 32'h100, 32'hA5A5A5A5, 4'hF, 3'b111, 32'h0, 1);
    look();
    chk("m1_release", 32'(bus.grant_o), 32'd0);
    tick();
    look();
    chk("rr_m0", 32'(bus.grant_o), 32'h1);

    // m0 4-beat burst with m1 requesting throughout
    tick();
    for (int i = 0; i < 4; i++)
      beat(0, 1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'hF, (i == 3) ? 3'b111 : 3'b010,
           32'h1000 + 32'(i), (i == 1) ? 1 : ((i == 3) ? 2 : 0));
    look();
    chk("burst_idle", 32'(bus.grant_o), 32'd0);
    tick();
    look();
    chk("burst_then_m1", 32'(bus.grant_o), 32'h2);
    tick();
    beat(1, 1'b0, 32'h300, 32'h0, 4'h3, 3'b111, 32'hCAFEF00D, 0);

    // Stall timeout: m0 strobes, bridge never acks
    bus.m1_cyc_i = 0;
    drive_m(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 3'b000);
    look();
    chk("to_pre_idle", 32'(bus.grant_o), 32'd0);
    tick();
    look();
    chk("to_grant", 32'(bus.grant_o), 32'h1);
    n = 0;
    while (bus.m0_err_o !== 1'b1 && n < 20) begin
      look();
      n++;
    end
    chk("to_latency", 32'(n), 32'd8);
    chk("to_s_cyc",   32'(bus.s_cyc_o), 32'd0);
    chk("to_s_stb",   32'(bus.s_stb_o), 32'd0);
    chk("to_m1_err",  32'(bus.m1_err_o), 32'd0);
    tick();
    bus.m0_cyc_i = 0;
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    look();
    chk("to_grant_off", 32'(bus.grant_o), 32'd0);
    chk("to_err_pulse", 32'(bus.m0_err_o), 32'd0);

    // Stray ack while idle
    tick();
    bus.s_ack_i = 1'b1;
    look();
    chk("idle_ack_drop", 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'd0);
    tick();
    bus.s_ack_i = 1'b0;
    look();
    chk("idle_stay", 32'(bus.grant_o), 32'd0);

    // Reset in the middle of an m1 burst
    tick();
    bus.m1_cyc_i = 1;
    tick();
    look();
    chk("m1_alone", 32'(bus.grant_o), 32'h2);
    tick();
    beat(1, 1'b0, 32'h500, 32'h0, 4'hF, 3'b010, 32'h55, 0);
    drive_m(1, 1'b1, 1'b0, 32'h504, 32'h0, 4'hF, 3'b010);
    bus.s_ack_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_mid_ack",   32'({bus.m1_ack_o, bus.m0_ack_o}), 32'd0);
    chk("rst_mid_err",   32'({bus.m1_err_o, bus.m0_err_o}), 32'd0);
    chk("rst_mid_s",     32'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_cti_o}), 32'd0);
    chk("rst_mid_addr",  bus.s_addr_o, 32'd0);
    tick();
    bus.s_ack_i = 1'b0;
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    bus.m0_cyc_i = 1;
    tick();
    rst = 1'b0;
    look();
    chk("post_rst_idle", 32'(bus.grant_o), 32'd0);
    tick();
    look();
    chk("post_rst_m0", 32'(bus.grant_o), 32'h1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
